// File: rtl/seq_ram_p.sv
// seq_ram_p: single-port synchronous RAM with valid/ready requests,
// configurable read latency, read-during-write mode and a clear engine.
module seq_ram_p #(
    parameter int DATA_W     = 8,
    parameter int ADDR_W     = 6,
    parameter int DEPTH      = 2**ADDR_W,
    parameter int RD_LATENCY = 1,
    parameter int RDW_MODE   = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              wr,
    input  logic              rd,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] dout,
    output logic              rd_valid,
    output logic              clr_done
);

    typedef enum logic {
        CLEAR,
        IDLE
    } state_t;

    localparam logic [ADDR_W:0]   DEPTH_L = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST    = ADDR_W'(DEPTH - 1);
    localparam int                LAST_S  = RD_LATENCY - 1;

    state_t              state;
    logic [ADDR_W-1:0]   clr_cnt;
    logic [DATA_W-1:0]   mem [DEPTH];

    logic                acc;
    logic                in_range;
    logic                rd_go;
    logic                wr_go;
    logic [DATA_W-1:0]   rdata;

    logic [RD_LATENCY-1:0] pv;
    logic [DATA_W-1:0]     pd [RD_LATENCY];

    assign req_ready = (state == IDLE) && !clr;
    assign acc       = req_valid && req_ready;
    assign in_range  = {1'b0, addr} < DEPTH_L;
    assign rd_go     = acc && rd;
    assign wr_go     = acc && wr && in_range;

    // Out-of-range reads return zero; write-first forwards din.
    always_comb begin
        rdata = '0;
        if (in_range) begin
            if (wr && (RDW_MODE != 0))
                rdata = din;
            else
                rdata = mem[addr];
        end
    end

    always_ff @(posedge clk) begin
        if (state == CLEAR)
            mem[clr_cnt] <= '0;
        else if (wr_go)
            mem[addr] <= din;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= CLEAR;
            clr_cnt  <= '0;
            clr_done <= 1'b0;
        end else begin
            clr_done <= 1'b0;
            unique case (state)
                CLEAR: begin
                    if (clr_cnt == LAST) begin
                        state    <= IDLE;
                        clr_cnt  <= '0;
                        clr_done <= 1'b1;
                    end else begin
                        clr_cnt <= clr_cnt + 1'b1;
                    end
                end
                IDLE: begin
                    if (clr) begin
                        state   <= CLEAR;
                        clr_cnt <= '0;
                    end
                end
                default: state <= CLEAR;
            endcase
        end
    end

    // Read pipeline runs independently of the clear engine.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pv       <= '0;
            rd_valid <= 1'b0;
            dout     <= '0;
            for (int i = 0; i < RD_LATENCY; i++)
                pd[i] <= '0;
        end else begin
            pv[0] <= rd_go;
            if (rd_go)
                pd[0] <= rdata;
            for (int i = 1; i < RD_LATENCY; i++) begin
                pv[i] <= pv[i-1];
                pd[i] <= pd[i-1];
            end
            rd_valid <= pv[LAST_S];
            if (pv[LAST_S])
                dout <= pd[LAST_S];
        end
    end

endmodule

// File: tb/tb_seq_ram_p.sv
// Bench for seq_ram_p: two configurations driven in lockstep,
// checked by per-instance scoreboards popped on rd_valid.
module tb_seq_ram_p;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       clr;
    logic       req_valid;
    logic       wr;
    logic       rd;
    logic [5:0] addr;
    logic [7:0] din;

    logic       rdy_a, rdy_b;
    logic [7:0] dout_a, dout_b;
    logic       rv_a, rv_b;
    logic       done_a, done_b;

    typedef struct {
        logic [7:0] d;
        int         due;
    } exp_t;

    exp_t qa[$];
    exp_t qb[$];
    exp_t ea, eb;

    int nvec = 0;
    int nerr = 0;
    int cyc  = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    seq_ram_p #(
        .DATA_W(8), .ADDR_W(6), .DEPTH(64),
        .RD_LATENCY(1), .RDW_MODE(0)
    ) dut_a (
        .clk(clk), .rst_n(rst_n), .clr(clr),
        .req_valid(req_valid), .req_ready(rdy_a),
        .wr(wr), .rd(rd), .addr(addr), .din(din),
        .dout(dout_a), .rd_valid(rv_a), .clr_done(done_a)
    );

    seq_ram_p #(
        .DATA_W(8), .ADDR_W(6), .DEPTH(48),
        .RD_LATENCY(2), .RDW_MODE(1)
    ) dut_b (
        .clk(clk), .rst_n(rst_n), .clr(clr),
        .req_valid(req_valid), .req_ready(rdy_b),
        .wr(wr), .rd(rd), .addr(addr), .din(din),
        .dout(dout_b), .rd_valid(rv_b), .clr_done(done_b)
    );

    function automatic void chk(string n, logic [31:0] act, logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", n, act, exp, $time);
        end
    endfunction

    always @(negedge clk) begin
        if (rst_n) begin
            if (rv_a) begin
                if (qa.size() == 0) begin
                    chk("a_unexpected_rd_valid", 32'(rv_a), 32'(0));
                end else begin
                    ea = qa.pop_front();
                    chk("a_dout", 32'(dout_a), 32'(ea.d));
                    chk("a_latency", 32'(cyc), 32'(ea.due));
                end
            end
            if (rv_b) begin
                if (qb.size() == 0) begin
                    chk("b_unexpected_rd_valid", 32'(rv_b), 32'(0));
                end else begin
                    eb = qb.pop_front();
                    chk("b_dout", 32'(dout_b), 32'(eb.d));
                    chk("b_latency", 32'(cyc), 32'(eb.due));
                end
            end
        end
    end

    task automatic issue(input logic w, input logic r, input logic [5:0] a,
                         input logic [7:0] d, input logic [7:0] xa,
                         input logic [7:0] xb);
        req_valid = 1'b1;
        wr        = w;
        rd        = r;
        addr      = a;
        din       = d;
        if (r) begin
            qa.push_back('{xa, cyc + 2});
            qb.push_back('{xb, cyc + 3});
        end
        @(negedge clk);
    endtask

    task automatic idle();
        req_valid = 1'b0;
        wr        = 1'b0;
        rd        = 1'b0;
        @(negedge clk);
    endtask

    task automatic reset_chk();
        chk("a_rst_ready", 32'(rdy_a), 32'(0));
        chk("a_rst_dout", 32'(dout_a), 32'(0));
        chk("a_rst_rd_valid", 32'(rv_a), 32'(0));
        chk("a_rst_clr_done", 32'(done_a), 32'(0));
        chk("b_rst_ready", 32'(rdy_b), 32'(0));
        chk("b_rst_dout", 32'(dout_b), 32'(0));
        chk("b_rst_rd_valid", 32'(rv_b), 32'(0));
        chk("b_rst_clr_done", 32'(done_b), 32'(0));
    endtask

    // Called just before the edge that clears address 0.
    task automatic wait_clear();
        for (int k = 1; k <= 66; k++) begin
            @(negedge clk);
            chk("a_clear_ready", 32'(rdy_a), 32'(k >= 64));
            chk("a_clr_done", 32'(done_a), 32'(k == 64));
            chk("b_clear_ready", 32'(rdy_b), 32'(k >= 48));
            chk("b_clr_done", 32'(done_b), 32'(k == 48));
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        clr       = 1'b0;
        req_valid = 1'b0;
        wr        = 1'b0;
        rd        = 1'b0;
        addr      = '0;
        din       = '0;

        repeat (2) @(negedge clk);
        reset_chk();
        rst_n = 1'b1;
        wait_clear();

        for (int i = 0; i < 64; i++)
            issue(1'b0, 1'b1, 6'(i), 8'h00, 8'h00, 8'h00);
        idle();

        issue(1'b1, 1'b0, 6'd3, 8'hA5, 8'h00, 8'h00);
        issue(1'b0, 1'b1, 6'd3, 8'h00, 8'hA5, 8'hA5);
        idle();
        idle();

        issue(1'b1, 1'b0, 6'd7, 8'h11, 8'h00, 8'h00);
        issue(1'b1, 1'b1, 6'd7, 8'h22, 8'h11, 8'h22);
        issue(1'b0, 1'b1, 6'd7, 8'h00, 8'h22, 8'h22);

        issue(1'b1, 1'b0, 6'd50, 8'hFF, 8'h00, 8'h00);
        issue(1'b0, 1'b1, 6'd50, 8'h00, 8'hFF, 8'h00);
        issue(1'b1, 1'b0, 6'd47, 8'h3C, 8'h00, 8'h00);
        issue(1'b0, 1'b1, 6'd47, 8'h00, 8'h3C, 8'h3C);

        issue(1'b1, 1'b0, 6'd10, 8'h5A, 8'h00, 8'h00);
        issue(1'b0, 1'b1, 6'd10, 8'h00, 8'h5A, 8'h5A);

        clr       = 1'b1;
        req_valid = 1'b1;
        wr        = 1'b1;
        rd        = 1'b1;
        addr      = 6'd10;
        din       = 8'h99;
        #1;
        chk("a_clr_blocks_ready", 32'(rdy_a), 32'(0));
        chk("b_clr_blocks_ready", 32'(rdy_b), 32'(0));
        @(negedge clk);
        clr       = 1'b0;
        req_valid = 1'b0;
        wr        = 1'b0;
        rd        = 1'b0;
        wait_clear();

        issue(1'b0, 1'b1, 6'd10, 8'h00, 8'h00, 8'h00);
        issue(1'b0, 1'b1, 6'd3, 8'h00, 8'h00, 8'h00);
        issue(1'b1, 1'b0, 6'd5, 8'h77, 8'h00, 8'h00);
        issue(1'b0, 1'b1, 6'd5, 8'h00, 8'h77, 8'h77);
        repeat (4) idle();

        req_valid = 1'b1;
        rd        = 1'b1;
        wr        = 1'b0;
        addr      = 6'd5;
        @(posedge clk);
        #1;
        rst_n     = 1'b0;
        req_valid = 1'b0;
        rd        = 1'b0;
        #1;
        chk("a_async_rst_dout", 32'(dout_a), 32'(0));
        chk("b_async_rst_dout", 32'(dout_b), 32'(0));
        repeat (3) begin
            @(negedge clk);
            reset_chk();
        end
        rst_n = 1'b1;
        wait_clear();

        issue(1'b0, 1'b1, 6'd5, 8'h00, 8'h00, 8'h00);
        repeat (5) idle();
        chk("a_scoreboard_drained", 32'(qa.size()), 32'(0));
        chk("b_scoreboard_drained", 32'(qb.size()), 32'(0));

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/seq_ram_p.md
# seq_ram_p

Parametrised single-port synchronous RAM with a valid/ready request interface, configurable read latency and read-during-write mode. It also has a hardware clear engine that zeroes the array one word per cycle, after reset and on demand. It is the next-generation replacement for the fixed 64x8 sequential RAM used in the environment-class test designs, and it sits behind a driver/monitor pair as a generic storage DUT.

## Interface
- DATA_W, 8, data word width in bits
- ADDR_W, 6, address width in bits
- DEPTH, 2**ADDR_W, number of words; must satisfy 2 <= DEPTH <= 2**ADDR_W
- RD_LATENCY, 1, read latency in cycles; legal values 1 or 2
- RDW_MODE, 0, read-during-write result; 0 = old data (read-first), 1 = new data (write-first)

- clk  input  1  clock; all state changes on the rising edge
- rst_n  input  1  reset, asynchronous assert, active-low; one clock, reset is asynchronous and active-low
- clr  input  1  request a full-array clear; sampled only in IDLE
- req_valid  input  1  request present this cycle
- req_ready  output  1  block can accept a request this cycle
- wr  input  1  write enable qualifying the request
- rd  input  1  read enable qualifying the request
- addr  input  ADDR_W  word address
- din  input  DATA_W  write data
- dout  output  DATA_W  read data, valid when rd_valid=1
- rd_valid  output  1  one-cycle pulse marking dout valid
- clr_done  output  1  one-cycle pulse on clear completion

## Operation
- FSM states: CLEAR, IDLE. The reset state is CLEAR with clr_cnt=0.
- CLEAR: each edge writes mem[clr_cnt]=0 and increments clr_cnt. On the edge that writes DEPTH-1, the FSM moves to IDLE, clr_cnt returns to 0, and clr_done pulses high for the following cycle.
- IDLE: clr=1 moves the FSM to CLEAR on the next edge.
- req_ready = (state==IDLE) && !clr. The ready output is combinational, so clr has priority over a same-cycle request.
- A request is accepted on an edge where req_valid && req_ready.
- Accepted wr=1: mem[addr] <= din.
- Accepted rd=1: the read is issued. Accepted wr=0, rd=0 is a no-op.
- Accepted wr=1 and rd=1 (same addr): the write is performed. The read returns pre-write data if RDW_MODE=0, or din if RDW_MODE=1.
- addr >= DEPTH: the write is dropped. A read returns 0 and still produces rd_valid.
- The memory array itself has no reset. Zeroing is done only by the clear engine, so content is defined once clr_done has fired.
- Reads already in flight when a clear starts still complete normally with their captured data.
- dout holds its last value between reads.

## Timing
- Reset values (while rst_n=0): state=CLEAR, clr_cnt=0, req_ready=0, dout=0, rd_valid=0, clr_done=0, read pipeline flushed.
- After rst_n rises, the first edge clears address 0. Edge k clears address k-1. req_ready goes high after edge DEPTH. clr_done is high for the cycle after edge DEPTH.
- clr sampled high at edge N in IDLE: req_ready falls immediately (combinational). Address 0 is cleared at edge N+1. req_ready rises after edge N+DEPTH.
- Read accepted at edge N: dout and rd_valid update at edge N+RD_LATENCY. rd_valid is high for exactly one cycle per accepted read.
- Back-to-back reads give one result per cycle with no bubbles, for either latency.
- A write at edge N is visible to a read accepted at edge N+1 or later.
- rst_n asserted mid-clear or mid-read: all outputs go to their reset values immediately. In-flight reads are discarded, with no rd_valid. The clear restarts from address 0 after release.

## Test plan
- Reset release, DEPTH=64 -> req_ready=0 for 64 cycles. clr_done is a single pulse after edge 64. Reading all 64 addresses returns 0x00.
- Write 0xA5 to addr 3, then read addr 3 (RD_LATENCY=1 and 2) -> dout=0xA5 with rd_valid at exactly edge +1 / +2. rd_valid is low otherwise.
- Preload addr 7=0x11, then simultaneous wr=1, rd=1, addr 7, din=0x22 -> dout=0x11 (RDW_MODE=0) or 0x22 (RDW_MODE=1). A later read of addr 7 returns 0x22.
- Write 0x5A to addr 10, pulse clr with req_valid=1 in the same cycle -> the request is not accepted. After DEPTH cycles clr_done pulses, and reading addr 10 returns 0x00.
- DEPTH=48, ADDR_W=6: write 0xFF to addr 50, then read addr 50 -> dout=0x00 with rd_valid=1. Addr 47 remains writable/readable.
- Issue a read, then drop rst_n before it completes -> no rd_valid, dout=0, and the clear sequence restarts from address 0 on release.
